// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   KEYMAP        : key code for each matrix position, index = row*4 + col
//   KEY_*         : code ranges understood by the music decoder
//   key_state_e   : encoder state (no key / single key / several keys)
//   popcount16    : number of set bits in a 16-bit keypad frame
//   lowest_index  : position of the lowest set bit of a frame
package keypad_pkg;

    localparam logic [3:0] KEY_NOTE_MIN = 4'h1;
    localparam logic [3:0] KEY_NOTE_MAX = 4'h7;
    localparam logic [3:0] KEY_OCT_LO   = 4'hA;
    localparam logic [3:0] KEY_OCT_MID  = 4'hB;
    localparam logic [3:0] KEY_OCT_HI   = 4'hC;

    // '*' is reported as E and '#' as F.
    localparam logic [3:0] KEYMAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_MULTI   = 2'd2
    } key_state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] f);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(f[i]);
        end
        return cnt;
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic logic [3:0] lowest_index(input logic [15:0] f);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (f[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Frame-level debouncer for the keypad scanner.
//   clk, sys_rst_n : system clock, asynchronous active-low reset
//   raw_frame      : complete 16-bit pressed map (bit = row*4 + col)
//   frame_end      : one-cycle strobe, raw_frame is complete and new
//   deb_frame      : last frame seen DEBOUNCE_FRAMES times in a row
//   deb_update     : one-cycle strobe, deb_frame was (re)loaded
module keypad_frame_debounce #(
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic [15:0] raw_frame,
    input  logic        frame_end,
    output logic [15:0] deb_frame,
    output logic        deb_update
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_FRAMES);

    logic [15:0] prev_frame;
    logic [7:0]  stable_cnt;
    logic [7:0]  cnt_next;

    // Counter saturates so a long hold keeps reloading the same frame.
    always_comb begin
        cnt_next = 8'd0;
        if (raw_frame == prev_frame) begin
            cnt_next = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prev_frame <= '0;
            stable_cnt <= '0;
            deb_frame  <= '0;
            deb_update <= 1'b0;
        end else begin
            deb_update <= 1'b0;
            if (frame_end) begin
                prev_frame <= raw_frame;
                stable_cnt <= cnt_next;
                if (cnt_next == CNT_MAX) begin
                    deb_frame  <= raw_frame;
                    deb_update <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low matrix keypad scanner, debouncer and key encoder.
//   clk, sys_rst_n : 100 MHz system clock, asynchronous active-low reset
//   col_in         : column sense, active-low, asynchronous to clk
//   row_out        : row drive, active-low, exactly one row low
//   keyboard_data  : code of the current or last valid key
//   IsPressed      : high while exactly one debounced key is held
//   key_valid      : one-cycle pulse on each new key press event
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] keyboard_data,
    output logic       IsPressed,
    output logic       key_valid
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       col_sync_p0, col_sync_p1;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic             sample;
    logic [15:0]      raw_frame;
    logic             frame_end;
    logic [15:0]      deb_frame;
    logic             deb_update;

    key_state_e       state_q, state_d;
    logic [3:0]       code_q, code_d;
    logic [3:0]       idx_q, idx_d;
    logic             kv_q, kv_d;
    logic [4:0]       n_keys;
    logic [3:0]       key_idx;

    // ---- stage 0/1: column synchronizer
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col_sync_p0 <= 4'hF;
            col_sync_p1 <= 4'hF;
        end else begin
            col_sync_p0 <= col_in;
            col_sync_p1 <= col_sync_p0;
        end
    end

    // ---- scan divider, row drive and frame assembly
    // Sampling at the last divider count leaves the columns most of the
    // row period to settle through the pull-ups and the synchronizer.
    assign sample  = (div_cnt == DIV_LAST);
    assign row_out = ~(4'b0001 << row_idx);

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt   <= '0;
            row_idx   <= 2'd0;
            raw_frame <= '0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= sample && (row_idx == 2'd3);
            if (sample) begin
                div_cnt                         <= '0;
                row_idx                         <= row_idx + 2'd1;
                raw_frame[{row_idx, 2'b00} +: 4] <= ~col_sync_p1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    keypad_frame_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .raw_frame  (raw_frame),
        .frame_end  (frame_end),
        .deb_frame  (deb_frame),
        .deb_update (deb_update)
    );

    // ---- encoding FSM, evaluated only when a debounced frame arrives
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        kv_d    = 1'b0;
        n_keys  = popcount16(deb_frame);
        key_idx = lowest_index(deb_frame);
        if (deb_update) begin
            case (state_q)
                ST_IDLE: begin
                    if (n_keys == 5'd1) begin
                        state_d = ST_PRESSED;
                        code_d  = KEYMAP[key_idx];
                        idx_d   = key_idx;
                        kv_d    = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (n_keys == 5'd0) begin
                        state_d = ST_IDLE;
                    end else if (n_keys == 5'd1) begin
                        // Roll-over: a different single key replaces the held one.
                        if (key_idx != idx_q) begin
                            code_d = KEYMAP[key_idx];
                            idx_d  = key_idx;
                            kv_d   = 1'b1;
                        end
                    end else begin
                        state_d = ST_MULTI;
                    end
                end
                ST_MULTI: begin
                    if (n_keys == 5'd0) begin
                        state_d = ST_IDLE;
                    end else if (n_keys == 5'd1) begin
                        state_d = ST_PRESSED;
                        code_d  = KEYMAP[key_idx];
                        idx_d   = key_idx;
                        kv_d    = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= 4'h0;
            idx_q   <= 4'd0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            kv_q    <= kv_d;
        end
    end

    assign keyboard_data = code_q;
    assign IsPressed     = (state_q == ST_PRESSED);
    assign key_valid     = kv_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
module tb_keypad_scan_encoder;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int LAT      = (DEB + 2) * FRAME + 4;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  keyboard_data;
    logic        IsPressed;
    logic        key_valid;

    logic [15:0] keys = '0;
    logic [15:0] keys_last = '0;
    int          since = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_scan_encoder #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEB)
    ) dut (
        .clk           (clk),
        .sys_rst_n     (sys_rst_n),
        .col_in        (col_in),
        .row_out       (row_out),
        .keyboard_data (keyboard_data),
        .IsPressed     (IsPressed),
        .key_valid     (key_valid)
    );

    // Physical keypad: a held key shorts its row to its column.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
            end
        end
    end

    // Cycles the current key set has been held unchanged.
    always @(posedge clk) begin
        if (!sys_rst_n || keys != keys_last) since <= 0;
        else if (since < 100000) since <= since + 1;
        keys_last <= keys;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] code_of(input int idx);
        string m;
        int    ch;
        m  = "123A456B789CE0FD";
        ch = m[idx];
        if (ch >= "0" && ch <= "9") return 4'(ch - "0");
        return 4'(ch - "A" + 10);
    endfunction

    // Model: what the keypad must report once a key set has been held long
    // enough, derived from the held set itself.
    int         m_state = 0;   // 0 nothing held, 1 single key, 2 several keys
    int         m_idx = -1;
    logic [3:0] m_code = 4'h0;
    int         exp_kv = 0;
    int         dut_kv = 0;
    logic       kv_prev = 1'b0;
    logic [3:0] exp_code_v;
    logic       exp_pressed_v;

    task automatic model_take(input int idx);
        m_state = 1;
        m_idx   = idx;
        m_code  = code_of(idx);
        exp_kv++;
    endtask

    task automatic model_apply(input logic [15:0] set);
        int n, idx;
        n = $countones(set);
        idx = -1;
        for (int i = 15; i >= 0; i--) if (set[i]) idx = i;
        case (m_state)
            0: if (n == 1) model_take(idx);
            1: begin
                if (n == 0) m_state = 0;
                else if (n == 1) begin
                    if (idx != m_idx) model_take(idx);
                end else m_state = 2;
            end
            default: begin
                if (n == 0) m_state = 0;
                else if (n == 1) model_take(idx);
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (!sys_rst_n) begin
            m_state = 0;
            m_idx   = -1;
            m_code  = 4'h0;
            kv_prev = 1'b0;
        end else begin
            if (key_valid) dut_kv++;
            check("kv_back_to_back", 32'(kv_prev & key_valid), 32'd0);
            check("row_one_low", 32'($countones(~row_out)), 32'd1);
            if (since == LAT) model_apply(keys);
            if (since >= LAT) begin
                exp_code_v    = m_code;
                exp_pressed_v = (m_state == 1);
                check("model_code", 32'(keyboard_data), 32'(exp_code_v));
                check("model_pressed", 32'(IsPressed), 32'(exp_pressed_v));
                check("model_kv_count", 32'(dut_kv), 32'(exp_kv));
            end
            kv_prev = key_valid;
        end
    end

    task automatic set_keys(input logic [15:0] v);
        @(posedge clk);
        #1 keys = v;
    endtask

    task automatic settle();
        repeat (LAT + 4) @(negedge clk);
    endtask

    int          kv0;
    int          first;
    int          hits;
    logic [3:0]  exp_row;
    logic [3:0]  star_code [3];
    int          star_idx  [3];

    initial begin
        star_idx[0] = 12; star_code[0] = 4'hE;
        star_idx[1] = 14; star_code[1] = 4'hF;
        star_idx[2] = 3;  star_code[2] = 4'hA;

        // Reset values and row stepping
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_row", 32'(row_out), 32'hE);
        check("rst_code", 32'(keyboard_data), 32'h0);
        check("rst_pressed", 32'(IsPressed), 32'h0);
        check("rst_kv", 32'(key_valid), 32'h0);
        sys_rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_row = 4'hF ^ (4'b0001 << ((k / 4) % 4));
            check("row_step", 32'(row_out), 32'(exp_row));
        end
        settle();

        // Press row1/col2 -> 6
        kv0 = dut_kv;
        first = -1;
        set_keys(16'h1 << 6);
        for (int t = 0; t < 5 * FRAME + 4; t++) begin
            @(negedge clk);
            if (IsPressed && first < 0) first = t;
        end
        check("press6_within_bound", 32'(first >= 0), 32'd1);
        repeat (10 * FRAME - (5 * FRAME + 4)) @(negedge clk);
        check("press6_code", 32'(keyboard_data), 32'h6);
        check("press6_pressed", 32'(IsPressed), 32'h1);
        check("press6_one_kv", 32'(dut_kv - kv0), 32'd1);
        set_keys('0);
        settle();
        check("release6_pressed", 32'(IsPressed), 32'h0);
        check("release6_code_held", 32'(keyboard_data), 32'h6);

        // Bounce on row2/col3, then hold -> C
        kv0 = dut_kv;
        hits = 0;
        for (int b = 0; b < 9; b++) begin
            set_keys(keys ^ (16'h1 << 11));
            repeat (8) begin
                @(negedge clk);
                if (IsPressed) hits++;
            end
        end
        check("bounce_no_press", 32'(hits), 32'd0);
        check("bounce_final_held", 32'(keys), 32'h0800);
        settle();
        check("bounce_code", 32'(keyboard_data), 32'hC);
        check("bounce_pressed", 32'(IsPressed), 32'h1);
        check("bounce_one_kv", 32'(dut_kv - kv0), 32'd1);
        set_keys('0);
        settle();

        // Roll-over: 1, then 1+5, then 5
        kv0 = dut_kv;
        set_keys(16'h0001);
        settle();
        check("roll_code1", 32'(keyboard_data), 32'h1);
        check("roll_pressed1", 32'(IsPressed), 32'h1);
        set_keys(16'h0021);
        settle();
        check("roll_multi_pressed", 32'(IsPressed), 32'h0);
        check("roll_multi_code", 32'(keyboard_data), 32'h1);
        set_keys(16'h0020);
        settle();
        check("roll_code5", 32'(keyboard_data), 32'h5);
        check("roll_pressed5", 32'(IsPressed), 32'h1);
        check("roll_two_kv", 32'(dut_kv - kv0), 32'd2);
        set_keys('0);
        settle();

        // Star, hash and octave key
        for (int s = 0; s < 3; s++) begin
            set_keys(16'h1 << star_idx[s]);
            settle();
            check("special_code", 32'(keyboard_data), 32'(star_code[s]));
            check("special_pressed", 32'(IsPressed), 32'h1);
            set_keys('0);
            settle();
        end

        // Reset while '7' is held
        set_keys(16'h1 << 8);
        settle();
        check("hold7_code", 32'(keyboard_data), 32'h7);
        check("hold7_pressed", 32'(IsPressed), 32'h1);
        @(posedge clk);
        #3 sys_rst_n = 1'b0;
        #1;
        check("async_rst_row", 32'(row_out), 32'hE);
        check("async_rst_code", 32'(keyboard_data), 32'h0);
        check("async_rst_pressed", 32'(IsPressed), 32'h0);
        check("async_rst_kv", 32'(key_valid), 32'h0);
        repeat (3) @(negedge clk);
        sys_rst_n = 1'b1;
        hits = 0;
        for (int t = 0; t < DEB * FRAME; t++) begin
            @(negedge clk);
            if (IsPressed) hits++;
        end
        check("rst_redebounce_no_early_press", 32'(hits), 32'd0);
        repeat (LAT + 8 - DEB * FRAME) @(negedge clk);
        check("rst_hold7_code", 32'(keyboard_data), 32'h7);
        check("rst_hold7_pressed", 32'(IsPressed), 32'h1);
        set_keys('0);
        settle();
        check("final_pressed", 32'(IsPressed), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_encoder.md
Name: keypad_scan_encoder

Overview:
Scans a 4x4 active-low matrix keypad, debounces it and encodes a single held key into the 4-bit key code plus pressed flag consumed by the electronic-keyboard decoder. This is the producer end of the keyboard_data/IsPressed interface. Codes 1-7 select notes and A-C select the octave. Sits between the board keypad pins and the speaker/music decoder; runs on the 100 MHz system clock.

Parameters:
SCAN_DIV, 100000, clk cycles each row is driven (1 ms at 100 MHz); must be >= 4
DEBOUNCE_FRAMES, 8, consecutive identical full-keypad frames required before the debounced state updates; range 1-255

Ports:
clk  input  1  system clock, 100 MHz
sys_rst_n  input  1  asynchronous active-low reset
col_in  input  4  keypad column sense, active-low, externally pulled up, asynchronous to clk
row_out  output  4  keypad row drive, active-low, exactly one bit low at all times
keyboard_data  output  4  encoded key code of the current or last valid key
IsPressed  output  1  high while exactly one debounced key is held
key_valid  output  1  one-cycle pulse on each new key press event

Behaviour:
- Reset values: row_out=4'b1110, keyboard_data=4'h0, IsPressed=0, key_valid=0; divider, row index, frame registers and stable counter all cleared. Reset mid-frame discards the partial frame and the debounce history.
- col_in passes through a 2-FF synchronizer before any use.
- Divider counts 0..SCAN_DIV-1. Row index r (0..3) advances when the divider wraps. row_out = ~(1<<r). Row 3 wraps to row 0.
- Sample point: on divider count SCAN_DIV-1, raw[r*4+c] = ~col_sync[c]. Raw bit 1 means pressed. This gives >= SCAN_DIV-3 cycles of settling.
- Frame end: sample of row 3. At frame end, compare the assembled 16-bit raw frame with the previous frame:
  - If equal, stable_cnt saturates at DEBOUNCE_FRAMES; otherwise stable_cnt=0.
  - When stable_cnt reaches DEBOUNCE_FRAMES, deb_frame <= raw frame.
- Encoding FSM, evaluated in the cycle after deb_frame updates:
  - IDLE (IsPressed=0)
    - deb_frame has exactly one set bit at index i -> PRESSED. keyboard_data=KEYMAP[i], IsPressed=1, key_valid=1 for one cycle.
    - Zero or more than one set bit -> stay in IDLE.
  - PRESSED
    - Zero set bits -> IDLE. IsPressed=0; keyboard_data holds its last value.
    - Exactly one set bit, same index -> stay.
    - Exactly one set bit, different index (roll-over) -> stay in PRESSED, update keyboard_data, key_valid=1.
    - More than one set bit (ghosting/chord) -> MULTI. IsPressed=0; keyboard_data holds.
  - MULTI
    - Zero set bits -> IDLE.
    - Exactly one set bit -> PRESSED with key_valid=1.
    - Otherwise stay in MULTI.
- KEYMAP, index = r*4 + c:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
  - '*' maps to E and '#' maps to F.
- Latency: from a clean stable press to IsPressed is at most (DEBOUNCE_FRAMES+2) frames + 4 clk (frame = 4*SCAN_DIV clk). Release latency has the same bound.
- key_valid never asserts two cycles in a row. Outputs change only on frame-end evaluation.

Decomposition:
- Shared package keypad_pkg holds:
  - KEYMAP (16 x 4-bit constant)
  - code constants KEY_NOTE_MIN=4'h1, KEY_NOTE_MAX=4'h7, KEY_OCT_LO=4'hA, KEY_OCT_MID=4'hB, KEY_OCT_HI=4'hC
  - state encoding IDLE/PRESSED/MULTI
- One natural sub-module: keypad_frame_debounce. It contains the stable counter, the previous-frame register and deb_frame, and takes the raw frame plus a frame_end strobe.
- Scan divider, synchronizer and encoding FSM stay in the top module.

Test Plan:
- All tests use SCAN_DIV=4 and DEBOUNCE_FRAMES=3 (frame = 16 clk) unless stated otherwise.
- Reset: check row_out=1110, IsPressed=0, keyboard_data=0. Then row_out steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every 4 clk.
- Press a row1/col2 model for 10 frames -> keyboard_data=4'h6, IsPressed=1 within 5 frames + 4 clk, exactly one key_valid pulse. Release -> IsPressed=0 and keyboard_data stays 6.
- Bounce: toggle row2/col3 every 9 clk for 5 frames, then hold -> no IsPressed during bouncing; after the hold, keyboard_data=4'hC and IsPressed=1, one key_valid.
- Roll-over: hold '1', then press '5', then release '1' -> keyboard_data goes 1, then MULTI with IsPressed=0, then 5 with IsPressed=1; two key_valid pulses in total.
- Star/hash: row3/col0 gives E; row3/col2 gives F; row0/col3 gives A.
- Assert sys_rst_n low while '7' is held and PRESSED -> all outputs return to reset values immediately. After release of reset with '7' still held, IsPressed rises again only after full debounce (>= 3 frames).
